// File: rtl/mean3_pkg.sv
// Shared constants and types for the mean-of-three unit arbiter.
package mean3_pkg;

  localparam int unsigned DW             = 8;
  localparam int unsigned START_WAIT_DEF = 4;
  localparam int unsigned TIMEOUT_DEF    = 255;

  // Arbiter FSM encoding
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Operands latched from the granted requester
  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
  } ops_t;

endpackage

// File: rtl/mean3_arbiter_if.sv
// Bus between the arbiter (master) and the shared mean-of-three unit (slave).
interface mean3_arbiter_if;

  logic                     u_start;
  logic [mean3_pkg::DW-1:0] u_InA;
  logic [mean3_pkg::DW-1:0] u_InB;
  logic                     u_busy;
  logic [mean3_pkg::DW-1:0] u_Out;

  modport master (output u_start, output u_InA, output u_InB, input u_busy, input u_Out);
  modport slave  (input u_start, input u_InA, input u_InB, output u_busy, output u_Out);

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin grant with a registered last-served pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       served,
  output logic       gnt_valid_c,
  output logic       gnt_id_c
);

  logic last;

  // Pointer starts at 1 so requester 0 wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= 1'b1;
    end else if (upd) begin
      last <= served;
    end
  end

  // Single request wins outright; a tie goes to the one not served last
  always_comb begin
    gnt_valid_c = |req;
    gnt_id_c    = 1'b0;
    if (req == 2'b10) begin
      gnt_id_c = 1'b1;
    end else if (req == 2'b11) begin
      gnt_id_c = ~last;
    end
  end

endmodule

// File: rtl/mean3_arbiter.sv
// Shares one mean-of-three unit between two requesters, with a watchdog.
module mean3_arbiter
  import mean3_pkg::*;
#(
  parameter int unsigned START_WAIT = START_WAIT_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
  parameter int unsigned CW         = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] b0,
  input  logic [DW-1:0] c0,
  output logic          ack0,
  output logic [DW-1:0] res0,
  input  logic          req1,
  input  logic [DW-1:0] a1,
  input  logic [DW-1:0] b1,
  input  logic [DW-1:0] c1,
  output logic          ack1,
  output logic [DW-1:0] res1,
  mean3_arbiter_if.master u,
  output logic          owner,
  output logic          active,
  output logic          err
);

  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  ops_t          ops, ops_n;
  logic          owner_n, ack0_n, ack1_n, err_n, start_n, active_n;
  logic [DW-1:0] res0_n, res1_n, ina_n, inb_n;
  logic          gnt_valid_c, gnt_id_c, upd_c;

  rr_arb2 u_rr (
    .clk         (clk),
    .reset       (reset),
    .req         ({req1, req0}),
    .upd         (upd_c),
    .served      (owner),
    .gnt_valid_c (gnt_valid_c),
    .gnt_id_c    (gnt_id_c)
  );

  // State, watchdog and all outputs are registered from their next values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ops       <= '0;
      owner     <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      res0      <= '0;
      res1      <= '0;
      err       <= 1'b0;
      active    <= 1'b0;
      u.u_start <= 1'b0;
      u.u_InA   <= '0;
      u.u_InB   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ops       <= ops_n;
      owner     <= owner_n;
      ack0      <= ack0_n;
      ack1      <= ack1_n;
      res0      <= res0_n;
      res1      <= res1_n;
      err       <= err_n;
      active    <= active_n;
      u.u_start <= start_n;
      u.u_InA   <= ina_n;
      u.u_InB   <= inb_n;
    end
  end

  // Next-state logic; unit-side outputs follow the state being entered
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ops_n   = ops;
    owner_n = owner;
    res0_n  = res0;
    res1_n  = res1;
    err_n   = err;
    ack0_n  = 1'b0;
    ack1_n  = 1'b0;
    upd_c   = 1'b0;

    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (gnt_valid_c) begin
          owner_n = gnt_id_c;
          ops_n.a = gnt_id_c ? a1 : a0;
          ops_n.b = gnt_id_c ? b1 : b0;
          ops_n.c = gnt_id_c ? c1 : c0;
          state_n = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (u.u_busy) begin
          cnt_n   = '0;
          state_n = S_RUN;
        end else if (cnt == CW'(START_WAIT - 1)) begin
          cnt_n   = '0;
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_RUN: begin
        if (!u.u_busy) begin
          // Result is captured as busy falls so res is valid alongside ack
          if (owner) begin
            res1_n = u.u_Out;
            ack1_n = 1'b1;
          end else begin
            res0_n = u.u_Out;
            ack0_n = 1'b1;
          end
          state_n = S_DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          cnt_n   = '0;
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DONE: begin
        upd_c   = 1'b1;
        state_n = S_IDLE;
      end
    endcase

    start_n  = (state_n == S_LAUNCH);
    active_n = (state_n != S_IDLE);
    ina_n    = '0;
    inb_n    = '0;
    if (state_n == S_LAUNCH) begin
      ina_n = ops_n.a;
      inb_n = ops_n.b;
    end else if (state_n == S_RUN) begin
      ina_n = ops_n.c;
      inb_n = ops_n.b;
    end
  end

endmodule

// File: tb/tb_mean3_arbiter.sv
// Self-checking bench for mean3_arbiter with a behavioural mean unit model.
module tb_mean3_arbiter;

  localparam int T_START  = 4;
  localparam int T_TO     = 20;
  localparam int BUSY_LEN = 6;
  localparam int M_NORMAL = 0;
  localparam int M_HUNG   = 1;
  localparam int M_DEAF   = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, ack0, ack1, owner, active, err;
  logic [7:0] a0, b0, c0, a1, b1, c1, res0, res1;

  int total = 0;
  int passed = 0;
  int last = 1;
  int mode = M_NORMAL;

  mean3_arbiter_if ubus ();

  mean3_arbiter #(.START_WAIT(T_START), .TIMEOUT(T_TO), .CW(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .c0(c0), .ack0(ack0), .res0(res0),
    .req1(req1), .a1(a1), .b1(b1), .c1(c1), .ack1(ack1), .res1(res1),
    .u(ubus), .owner(owner), .active(active), .err(err)
  );

  always #5 clk = ~clk;

  // Mean unit model: busy rises the cycle after start, C taken from InA mid-op
  logic [7:0] ma, mb, mc;
  int mcnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ubus.u_busy <= 1'b0;
      ubus.u_Out  <= 8'd0;
      mcnt        <= 0;
    end else if (ubus.u_busy) begin
      if (mode == M_HUNG) begin
        mcnt <= 2;
      end else begin
        if (mcnt == BUSY_LEN - 1) mc <= ubus.u_InA;
        if (mcnt == 1) begin
          ubus.u_busy <= 1'b0;
          ubus.u_Out  <= 8'((32'(ma) + 32'(mb) + 32'(mc)) / 32'd3);
        end
        mcnt <= mcnt - 1;
      end
    end else if (ubus.u_start && mode != M_DEAF) begin
      ma          <= ubus.u_InA;
      mb          <= ubus.u_InB;
      ubus.u_busy <= 1'b1;
      mcnt        <= BUSY_LEN;
    end
  end

  // Ack pulse counters and width tracking
  int ack0_cnt = 0, ack1_cnt = 0, ack_wide = 0;
  logic pa0 = 1'b0, pa1 = 1'b0;
  always @(negedge clk) begin
    if (ack0) ack0_cnt++;
    if (ack1) ack1_cnt++;
    if ((ack0 && pa0) || (ack1 && pa1)) ack_wide++;
    pa0 = ack0;
    pa1 = ack1;
  end

  function automatic int ref_mean(input int a, input int b, input int c);
    return (a + b + c) / 3;
  endfunction

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    if (id == 0) begin req0 = 1'b1; a0 = a; b0 = b; c0 = c; end
    else begin req1 = 1'b1; a1 = a; b1 = b; c1 = c; end
  endtask

  task automatic drop_req(input int id);
    if (id == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic wait_ack(input int budget, output int who);
    who = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        who = ack0 ? (ack1 ? 2 : 0) : 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0; mode = M_NORMAL;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    last = 1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({ack0, ack1, owner, active, err, ubus.u_start} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000", {ack0, ack1, owner, active, err, ubus.u_start});
    else passed++;
    total++;
    if ({res0, res1, ubus.u_InA, ubus.u_InB} !== 32'd0)
      $display("FAIL reset_data: got %h want 0", {res0, res1, ubus.u_InA, ubus.u_InB});
    else passed++;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({active, ubus.u_start, ack0, ack1} !== 4'b0)
      $display("FAIL idle_no_req: got %b want 0000", {active, ubus.u_start, ack0, ack1});
    else passed++;
  endtask

  task automatic test_single();
    int fall_idx, ack_idx, b0c, b1c;
    logic [7:0] l_ina, l_inb, r_ina, r_inb;
    bit seen_l, seen_r, prev_busy;
    fall_idx = -1; ack_idx = -1; seen_l = 0; seen_r = 0; prev_busy = 0;
    l_ina = 0; l_inb = 0; r_ina = 0; r_inb = 0;
    b0c = ack0_cnt; b1c = ack1_cnt;
    set_req(1, 8'($urandom), 8'($urandom), 8'($urandom));
    req1 = 1'b0;
    set_req(0, 8'd255, 8'd255, 8'd254);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (ubus.u_start && !seen_l) begin
        seen_l = 1; l_ina = ubus.u_InA; l_inb = ubus.u_InB;
        a0 = 8'($urandom); b0 = 8'($urandom); c0 = 8'($urandom);
      end
      if (active && !ubus.u_start && ubus.u_busy && !seen_r) begin
        seen_r = 1; r_ina = ubus.u_InA; r_inb = ubus.u_InB;
      end
      if (prev_busy && !ubus.u_busy && fall_idx < 0) fall_idx = i;
      prev_busy = ubus.u_busy;
      if (ack0 || ack1) begin ack_idx = i; break; end
    end
    req0 = 1'b0;
    total++;
    if ({l_ina, l_inb} !== {8'd255, 8'd255})
      $display("FAIL single_launch_ins: got %0d,%0d want 255,255", l_ina, l_inb);
    else passed++;
    total++;
    if ({r_ina, r_inb} !== {8'd254, 8'd255})
      $display("FAIL single_run_ins: got %0d,%0d want 254,255", r_ina, r_inb);
    else passed++;
    total++;
    if ({ack0, ack1} !== 2'b10) $display("FAIL single_ack: got %b want 10", {ack0, ack1});
    else passed++;
    total++;
    if (res0 !== 8'(ref_mean(255, 255, 254))) $display("FAIL single_res0: got %0d want 254", res0);
    else passed++;
    total++;
    if (ack_idx !== fall_idx + 1 || fall_idx < 0)
      $display("FAIL single_ack_latency: got ack at %0d busy low at %0d want ack one after", ack_idx, fall_idx);
    else passed++;
    @(negedge clk);
    total++;
    if (ack0 !== 1'b0) $display("FAIL single_ack_width: got ack0=%b want 0", ack0);
    else passed++;
    repeat (4) @(negedge clk);
    total++;
    if ((ack0_cnt - b0c) !== 1 || (ack1_cnt - b1c) !== 0)
      $display("FAIL single_ack_counts: got %0d,%0d want 1,0", ack0_cnt - b0c, ack1_cnt - b1c);
    else passed++;
    last = 0;
  endtask

  task automatic test_tie();
    int who;
    do_reset();
    set_req(0, 8'd10, 8'd20, 8'd30);
    set_req(1, 8'd1, 8'd2, 8'd3);
    wait_ack(40, who);
    total++;
    if (who !== 0 || owner !== 1'b0) $display("FAIL tie_first: got who=%0d owner=%b want 0,0", who, owner);
    else passed++;
    total++;
    if (res0 !== 8'd20 || res1 !== 8'd0) $display("FAIL tie_res_first: got %0d,%0d want 20,0", res0, res1);
    else passed++;
    drop_req(0);
    wait_ack(40, who);
    total++;
    if (who !== 1 || owner !== 1'b1) $display("FAIL tie_second: got who=%0d owner=%b want 1,1", who, owner);
    else passed++;
    total++;
    if (res1 !== 8'd2 || res0 !== 8'd20) $display("FAIL tie_res_second: got %0d,%0d want 20,2", res0, res1);
    else passed++;
    drop_req(1);
    last = 1;
  endtask

  task automatic test_fairness();
    int who, exp_o, wide0;
    int er[2];
    logic [7:0] oa[2], ob[2], oc[2];
    er[0] = int'(res0); er[1] = int'(res1);
    wide0 = ack_wide;
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      oa[r] = 8'($urandom); ob[r] = 8'($urandom); oc[r] = 8'($urandom);
      set_req(r, oa[r], ob[r], oc[r]);
    end
    for (int k = 0; k < 6; k++) begin
      exp_o = 1 - last;
      wait_ack(40, who);
      total++;
      if (who !== exp_o || int'(owner) !== exp_o)
        $display("FAIL fair_owner_%0d: got who=%0d owner=%b want %0d", k, who, owner, exp_o);
      else passed++;
      er[exp_o] = ref_mean(int'(oa[exp_o]), int'(ob[exp_o]), int'(oc[exp_o]));
      total++;
      if (int'(res0) !== er[0] || int'(res1) !== er[1])
        $display("FAIL fair_res_%0d: got %0d,%0d want %0d,%0d", k, res0, res1, er[0], er[1]);
      else passed++;
      last = exp_o;
      oa[exp_o] = 8'($urandom); ob[exp_o] = 8'($urandom); oc[exp_o] = 8'($urandom);
      set_req(exp_o, oa[exp_o], ob[exp_o], oc[exp_o]);
    end
    drop_req(0); drop_req(1);
    repeat (2) @(negedge clk);
    total++;
    if (ack_wide !== wide0) $display("FAIL fair_ack_width: got %0d wide acks want 0", ack_wide - wide0);
    else passed++;
  endtask

  task automatic test_hung();
    int run_idx, err_idx, diff, who, b0c, b1c;
    do_reset();
    mode = M_HUNG;
    b0c = ack0_cnt; b1c = ack1_cnt;
    run_idx = -1; err_idx = -1;
    set_req(0, 8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (run_idx < 0 && active && !ubus.u_start) run_idx = i;
      if (err) begin err_idx = i; break; end
    end
    drop_req(0);
    diff = (run_idx < 0 || err_idx < 0) ? -1 : err_idx - run_idx;
    total++;
    if (diff !== T_TO) $display("FAIL hung_err_time: got %0d cycles want %0d", diff, T_TO);
    else passed++;
    total++;
    if (active !== 1'b0 || ack0_cnt !== b0c || ack1_cnt !== b1c)
      $display("FAIL hung_abort: got active=%b acks=%0d,%0d want 0,0,0", active, ack0_cnt - b0c, ack1_cnt - b1c);
    else passed++;
    mode = M_NORMAL;
    for (int i = 0; i < 20 && ubus.u_busy; i++) @(negedge clk);
    set_req(1, 8'd3, 8'd6, 8'd9);
    wait_ack(40, who);
    total++;
    if (who !== 1 || res1 !== 8'd6) $display("FAIL hung_recover: got who=%0d res1=%0d want 1,6", who, res1);
    else passed++;
    total++;
    if (err !== 1'b1) $display("FAIL hung_err_sticky: got %b want 1", err);
    else passed++;
    drop_req(1);
    last = 1;
  endtask

  task automatic test_no_busy();
    int sc, rid, who, exp_o, b0c, b1c;
    bit seen;
    logic [7:0] oa[2], ob[2], oc[2];
    do_reset();
    mode = M_DEAF;
    sc = 0; seen = 0; rid = 1 - last;
    b0c = ack0_cnt; b1c = ack1_cnt;
    total++;
    if (err !== 1'b0) $display("FAIL deaf_err_pre: got %b want 0", err);
    else passed++;
    set_req(rid, 8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ubus.u_start) begin sc++; seen = 1; end
      else if (seen) break;
    end
    drop_req(rid);
    mode = M_NORMAL;
    total++;
    if (sc !== T_START) $display("FAIL deaf_start_len: got %0d want %0d", sc, T_START);
    else passed++;
    total++;
    if (err !== 1'b1 || active !== 1'b0 || ack0_cnt !== b0c || ack1_cnt !== b1c)
      $display("FAIL deaf_abort: got err=%b active=%b acks=%0d want 1,0,0", err, active, (ack0_cnt - b0c) + (ack1_cnt - b1c));
    else passed++;
    // an aborted operation must leave the round-robin pointer alone
    for (int r = 0; r < 2; r++) begin
      oa[r] = 8'($urandom); ob[r] = 8'($urandom); oc[r] = 8'($urandom);
      set_req(r, oa[r], ob[r], oc[r]);
    end
    for (int k = 0; k < 2; k++) begin
      exp_o = 1 - last;
      wait_ack(40, who);
      total++;
      if (who !== exp_o || int'(exp_o == 0 ? res0 : res1) !== ref_mean(int'(oa[exp_o]), int'(ob[exp_o]), int'(oc[exp_o])))
        $display("FAIL deaf_ptr_%0d: got who=%0d res=%0d,%0d want who=%0d", k, who, res0, res1, exp_o);
      else passed++;
      drop_req(exp_o);
      last = exp_o;
    end
  endtask

  task automatic test_reset_mid_run();
    int who;
    bit found;
    found = 0;
    @(negedge clk);
    set_req(0, 8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (active && !ubus.u_start && ubus.u_busy) begin found = 1; break; end
    end
    total++;
    if (!found) $display("FAIL rst_reach_run: got no RUN cycle want RUN within 20");
    else passed++;
    reset = 1'b1;
    req0 = 1'b0;
    #1;
    total++;
    if ({ubus.u_start, active, err, ack0, ack1} !== 5'b0)
      $display("FAIL rst_mid_flags: got %b want 00000", {ubus.u_start, active, err, ack0, ack1});
    else passed++;
    total++;
    if (res0 !== 8'd0 || res1 !== 8'd0) $display("FAIL rst_mid_res: got %0d,%0d want 0,0", res0, res1);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    last = 1;
    @(negedge clk);
    set_req(0, 8'd0, 8'd0, 8'd3);
    wait_ack(40, who);
    total++;
    if (who !== 0 || res0 !== 8'd1) $display("FAIL rst_after: got who=%0d res0=%0d want 0,1", who, res0);
    else passed++;
    drop_req(0);
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = 8'd0; b0 = 8'd0; c0 = 8'd0;
    a1 = 8'd0; b1 = 8'd0; c1 = 8'd0;
    test_reset();
    test_single();
    test_tie();
    test_fairness();
    test_hung();
    test_no_busy();
    test_reset_mid_run();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mean3_arbiter.md
Name: mean3_arbiter

Overview:
- Sequences and shares the 8-bit mean-of-three datapath unit (start / InA / InB / busy / Out interface) between two independent requesters.
- Latches a requester's three operands and launches the unit with A and B, then presents C on InA for the rest of the operation.
- Captures the result when busy falls and returns it to the owning requester with a one-cycle ack.
- Round-robin fairness; watchdog on a hung unit.

Parameters:
- START_WAIT, 4: max cycles u_start is held waiting for u_busy to rise before an error abort.
- TIMEOUT, 255: max cycles in RUN waiting for u_busy to fall before an error abort.
- CW, 8: width of the watchdog counter; must hold max(START_WAIT, TIMEOUT).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req0  in  1  requester 0 operation request; level, held until ack0.
- a0, b0, c0  in  8 each  requester 0 operands.
- ack0  out  1  one-cycle pulse: res0 valid.
- res0  out  8  requester 0 result, held until its next ack.
- req1, a1, b1, c1, ack1, res1: same as requester 0, for requester 1.
- u_start  out  1  start to mean unit.
- u_InA  out  8  unit InA: A during LAUNCH, C during RUN.
- u_InB  out  8  unit InB: B during LAUNCH and RUN.
- u_busy  in  1  unit busy.
- u_Out  in  8  unit result, valid when busy falls.
- owner  out  1  requester currently granted.
- active  out  1  high in LAUNCH, RUN and DONE.
- err  out  1  sticky watchdog error flag.

Behaviour:
- Reset values: all outputs 0, state IDLE, last-served pointer = 1 (so requester 0 wins the first tie), counter 0.
- IDLE:
  - Grant logic: only one req high -> grant it. Both high -> grant the requester that is not the last-served one.
  - On grant: latch a/b/c of the winner into opA/opB/opC, set owner, go to LAUNCH the next cycle.
  - No req -> stay in IDLE; u_start = 0, u_InA = u_InB = 0.
- LAUNCH:
  - u_start = 1, u_InA = opA, u_InB = opB, counter increments.
  - u_busy = 1 -> go to RUN, clear counter.
  - counter reaches START_WAIT -> set err, go to IDLE, no ack.
- RUN:
  - u_start = 0, u_InA = opC, u_InB = opB. The unit samples C on InA at its internal C-load step; the arbiter holds opC stable for the whole of RUN.
  - u_busy = 0 -> go to DONE.
  - counter reaches TIMEOUT -> set err, go to IDLE, no ack, pointer not updated.
- DONE (one cycle):
  - res<owner> <= u_Out, ack<owner> = 1 for exactly this cycle.
  - last-served <= owner; go to IDLE.
- Latency:
  - Grant to LAUNCH: 1 cycle.
  - ack occurs 1 cycle after u_busy is sampled low in RUN.
  - Minimum grant-to-ack: 3 cycles plus the unit's busy time.
- Re-arbitration: IDLE re-arbitrates on the cycle after DONE. A requester holding req through its ack is served again only if the other requester is idle.
- req dropped mid-operation: ignored. The operation completes and ack/res are still delivered. Operand changes after grant are ignored.
- res of the requester not being served is never modified.
- err: set only by the watchdog, cleared only by reset. The arbiter keeps serving after an error.
- reset mid-operation: immediate return to IDLE, u_start = 0, ack = 0, res cleared. The unit shares the same reset.
- Arithmetic: none inside the arbiter; the result is passed through unchanged.

Decomposition:
- Shared package mean3_pkg:
  - state encoding: IDLE, LAUNCH, RUN, DONE (2-bit);
  - default START_WAIT and TIMEOUT constants.
- One natural sub-module, rr_arb2: two-input round-robin grant with a last-served pointer. Combinational grant, registered pointer update on DONE.
- Everything else stays in mean3_arbiter.

Test Plan:
- Single request: req0 with a0=255, b0=255, c0=254, bench unit model has a 6-cycle busy -> u_InA=255 in LAUNCH then 254 in RUN; ack0 one cycle; res0=254; ack1 never asserted.
- Tie: req0 (10,20,30) and req1 (1,2,3) raised in the same cycle after reset -> requester 0 served first (res0=20), then requester 1 (res1=2); owner sequence 0,1.
- Fairness under contention: both reqs held high for 6 operations -> owner alternates 0,1,0,1,0,1; every ack is exactly one cycle wide.
- Hung unit: model holds u_busy=1 forever, TIMEOUT=20 -> err=1 twenty cycles after entering RUN; no ack; arbiter back in IDLE; next request (req1 with 3,6,9) completes with res1=6 and err stays 1.
- No busy response: model never raises busy, START_WAIT=4 -> u_start high 4 cycles then drops; err=1; no ack.
- Reset mid-RUN: assert reset while busy -> same cycle u_start=0, active=0, err=0, res0=res1=0; a fresh req0 (0,0,3) afterwards gives res0=1.
